// File: rtl/dom1_skinny_masker_pkg.sv
// Shared types and constants for the first-order DOM SKINNY input/output masker.
// The watchdog (enabled with DOM1_SKINNY_WDT_EN) uses WDT_LIMIT and WDT_W.
package dom1_skinny_masker_pkg;

    localparam int BLK_W     = 128;
    localparam int WDT_LIMIT = 1024;
    localparam int WDT_W     = 11;

    typedef logic [BLK_W-1:0] blk_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MASK_S = 3'd1,
        MASK_K = 3'd2,
        MASK_R = 3'd3,
        START  = 3'd4,
        RUN    = 3'd5,
        OUT    = 3'd6
    } state_t;

endpackage

// File: rtl/dom1_skinny_masker_if.sv
// Bundle of host request/response, randomness source and DOM-1 core connections.
// slave: the masker's view; master: the surrounding environment (host + core).
interface dom1_skinny_masker_if;
    import dom1_skinny_masker_pkg::*;

    logic in_valid;
    logic in_ready;
    blk_t pt;
    blk_t key;
    blk_t tweak;
    blk_t cnt;
    blk_t rnd_i;
    logic rnd_valid;
    blk_t sshi0;
    blk_t sshi1;
    blk_t kshi0;
    blk_t kshi1;
    blk_t ri;
    blk_t ti;
    blk_t cnti;
    logic core_rst;
    blk_t ssho0;
    blk_t ssho1;
    logic done;
    blk_t ct;
    logic out_valid;
    logic out_ready;
    logic err;

    modport slave (
        input  in_valid, pt, key, tweak, cnt, rnd_i, rnd_valid,
        input  ssho0, ssho1, done, out_ready,
        output in_ready, sshi0, sshi1, kshi0, kshi1, ri, ti, cnti,
        output core_rst, ct, out_valid, err
    );

    modport master (
        output in_valid, pt, key, tweak, cnt, rnd_i, rnd_valid,
        output ssho0, ssho1, done, out_ready,
        input  in_ready, sshi0, sshi1, kshi0, kshi1, ri, ti, cnti,
        input  core_rst, ct, out_valid, err
    );

endinterface

// File: rtl/dom1_share_split.sv
// Splits a value into two registered Boolean shares: sh0 = mask, sh1 = value ^ mask.
// Shares update only on load and otherwise hold, so the core sees stable inputs.
module dom1_share_split
    import dom1_skinny_masker_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  blk_t value,
    input  blk_t mask,
    output blk_t sh0,
    output blk_t sh1
);

    blk_t sh0_reg;
    blk_t sh1_reg;
    blk_t masked_next;

    genvar gi;
    generate
        for (gi = 0; gi < BLK_W; gi++) begin : g_bit
            assign masked_next[gi] = value[gi] ^ mask[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sh0_reg <= '0;
            sh1_reg <= '0;
        end else if (load) begin
            sh0_reg <= mask;
            sh1_reg <= masked_next;
        end
    end

    assign sh0 = sh0_reg;
    assign sh1 = sh1_reg;

endmodule

// File: rtl/dom1_skinny_masker.sv
// Masks an unmasked SKINNY request into DOM-1 shares, starts the external core and
// unmasks its result. Optional RUN watchdog when DOM1_SKINNY_WDT_EN is defined.
module dom1_skinny_masker
    import dom1_skinny_masker_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    dom1_skinny_masker_if.slave  bus
);

    state_t state_reg;
    state_t state_next;

    blk_t pt_reg;
    blk_t key_reg;
    blk_t tweak_reg;
    blk_t cnt_reg;
    blk_t msk_s_reg;
    blk_t msk_k_reg;
    blk_t ri_reg;
    blk_t ti_reg;
    blk_t cnti_reg;
    blk_t ct_reg;
    logic first_run_reg;

    blk_t sshi0_w;
    blk_t sshi1_w;
    blk_t kshi0_w;
    blk_t kshi1_w;

    logic accept;
    logic take_s;
    logic take_k;
    logic leave_r;
    logic finish;
    logic wdt_expire;

    assign accept  = (state_reg == IDLE)   && bus.in_valid;
    assign take_s  = (state_reg == MASK_S) && bus.rnd_valid;
    assign take_k  = (state_reg == MASK_K) && bus.rnd_valid;
    assign leave_r = (state_reg == MASK_R) && bus.rnd_valid;
    // The core may still show a stale done from its previous run in the first RUN cycle.
    assign finish  = (state_reg == RUN) && !first_run_reg && bus.done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)  state_next = MASK_S;
            MASK_S:  if (bus.rnd_valid) state_next = MASK_K;
            MASK_K:  if (bus.rnd_valid) state_next = MASK_R;
            MASK_R:  if (bus.rnd_valid) state_next = START;
            START:   state_next = RUN;
            RUN: begin
                if (finish)          state_next = OUT;
                else if (wdt_expire) state_next = IDLE;
            end
            OUT:     if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pt_reg        <= '0;
            key_reg       <= '0;
            tweak_reg     <= '0;
            cnt_reg       <= '0;
            msk_s_reg     <= '0;
            msk_k_reg     <= '0;
            ri_reg        <= '0;
            ti_reg        <= '0;
            cnti_reg      <= '0;
            ct_reg        <= '0;
            first_run_reg <= 1'b0;
        end else begin
            first_run_reg <= (state_reg == START);
            if (accept) begin
                pt_reg    <= bus.pt;
                key_reg   <= bus.key;
                tweak_reg <= bus.tweak;
                cnt_reg   <= bus.cnt;
            end
            if (take_s) msk_s_reg <= bus.rnd_i;
            if (take_k) msk_k_reg <= bus.rnd_i;
            // Shares are formed this cycle from pt_reg/key_reg, so the plain copies can go.
            if (leave_r) begin
                ri_reg   <= bus.rnd_i;
                ti_reg   <= tweak_reg;
                cnti_reg <= cnt_reg;
                pt_reg   <= '0;
                key_reg  <= '0;
            end
            if (finish) ct_reg <= bus.ssho0 ^ bus.ssho1;
        end
    end

    dom1_share_split u_state_split (
        .clk   (clk),
        .rst   (rst),
        .load  (leave_r),
        .value (pt_reg),
        .mask  (msk_s_reg),
        .sh0   (sshi0_w),
        .sh1   (sshi1_w)
    );

    dom1_share_split u_key_split (
        .clk   (clk),
        .rst   (rst),
        .load  (leave_r),
        .value (key_reg),
        .mask  (msk_k_reg),
        .sh0   (kshi0_w),
        .sh1   (kshi1_w)
    );

`ifdef DOM1_SKINNY_WDT_EN
    logic [WDT_W-1:0] wdt_reg;
    logic             err_reg;

    // Expires on the WDT_LIMIT-th RUN cycle without an accepted done.
    assign wdt_expire = (state_reg == RUN) && !finish && (wdt_reg == WDT_W'(WDT_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            err_reg <= wdt_expire;
            if (state_reg == RUN) wdt_reg <= wdt_reg + 1'b1;
            else                  wdt_reg <= '0;
        end
    end

    assign bus.err = err_reg;
`else
    assign wdt_expire = 1'b0;
    assign bus.err    = 1'b0;
`endif

    assign bus.in_ready  = (state_reg == IDLE) && !rst;
    assign bus.out_valid = (state_reg == OUT);
    assign bus.core_rst  = (state_reg == START);
    assign bus.ct        = ct_reg;
    assign bus.sshi0     = sshi0_w;
    assign bus.sshi1     = sshi1_w;
    assign bus.kshi0     = kshi0_w;
    assign bus.kshi1     = kshi1_w;
    assign bus.ri        = ri_reg;
    assign bus.ti        = ti_reg;
    assign bus.cnti      = cnti_reg;

endmodule

// File: tb/tb_dom1_skinny_masker.sv
// Directed bench for dom1_skinny_masker with a simple XOR core stand-in whose
// unmasked result is pt^key^tweak^cnt, so masks must cancel for ct to match.
module tb_dom1_skinny_masker;
    import dom1_skinny_masker_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dom1_skinny_masker_if bus();

    dom1_skinny_masker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Core stand-in: done appears core_lat cycles after the core_rst pulse.
    int         core_lat = 0;
    logic       core_hang = 1'b0;
    logic [7:0] core_cnt;
    logic       core_arm;
    int         rst_pulses = 0;

    always @(posedge clk) begin
        if (rst) begin
            core_arm <= 1'b0;
            core_cnt <= '0;
        end else if (bus.core_rst) begin
            core_arm <= 1'b1;
            core_cnt <= 8'(core_lat);
        end else if (core_arm && core_cnt != 0) begin
            core_cnt <= core_cnt - 8'd1;
        end
    end

    assign bus.done  = core_arm && (core_cnt == 8'd0) && !core_hang;
    assign bus.ssho0 = bus.sshi0 ^ bus.kshi0 ^ bus.ti ^ bus.ri;
    assign bus.ssho1 = bus.sshi1 ^ bus.kshi1 ^ bus.cnti ^ bus.ri;

    // Accepted plain values, used to check that they never leak onto the core side.
    blk_t acc_pt  = '0;
    blk_t acc_key = '0;

    always @(negedge clk) begin
        if (bus.core_rst) rst_pulses <= rst_pulses + 1;
        chk("pt_hidden",  128'(bus.sshi0 != '0 && bus.sshi1 == acc_pt), 128'd0);
        chk("key_hidden", 128'(bus.kshi0 != '0 && bus.kshi1 == acc_key), 128'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Accept a request and feed three masks, each preceded by gap idle rnd cycles.
    // Returns sampling at the negedge of the START cycle.
    task automatic start_req(input blk_t p, input blk_t k, input blk_t t, input blk_t c,
                             input blk_t ms, input blk_t mk, input blk_t mr,
                             input int gap, input bit junk_in);
        tick();
        bus.pt = p; bus.key = k; bus.tweak = t; bus.cnt = c;
        bus.in_valid = 1'b1;
        smp();
        chk("in_ready_idle", 128'(bus.in_ready), 128'd1);
        tick();
        acc_pt = p;
        acc_key = k;
        bus.pt = ~p; bus.key = ~k; bus.tweak = ~t; bus.cnt = ~c;
        bus.in_valid = junk_in;
        smp();
        chk("in_ready_busy", 128'(bus.in_ready), 128'd0);
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.rnd_valid = 1'b0;
                bus.rnd_i = {$urandom, $urandom, $urandom, $urandom};
                tick();
            end
            bus.rnd_valid = 1'b1;
            bus.rnd_i = (i == 0) ? ms : ((i == 1) ? mk : mr);
            tick();
        end
        bus.rnd_valid = 1'b0;
        bus.in_valid = 1'b0;
        smp();
        chk("core_rst", 128'(bus.core_rst), 128'd1);
        chk("sshi0", bus.sshi0, ms);
        chk("sshi1", bus.sshi1, p ^ ms);
        chk("kshi0", bus.kshi0, mk);
        chk("kshi1", bus.kshi1, k ^ mk);
        chk("ri", bus.ri, mr);
        chk("ti", bus.ti, t);
        chk("cnti", bus.cnti, c);
    endtask

    task automatic do_req(input blk_t p, input blk_t k, input blk_t t, input blk_t c,
                          input blk_t ms, input blk_t mk, input blk_t mr,
                          input int gap, input int lat, input int hold, input bit junk_in);
        blk_t exp_ct;
        int   n;
        int   p0;
        bit   held;
        bit   stable;
        exp_ct = p ^ k ^ t ^ c;
        core_lat = lat;
        core_hang = 1'b0;
        p0 = rst_pulses;
        start_req(p, k, t, c, ms, mk, mr, gap, junk_in);
        n = 0;
        held = 1'b1;
        while (!bus.out_valid && n < 2000) begin
            tick();
            smp();
            n++;
            if (bus.sshi0 !== ms || bus.sshi1 !== (p ^ ms) || bus.kshi1 !== (k ^ mk) ||
                bus.ri !== mr || bus.core_rst || bus.in_ready) held = 1'b0;
        end
        chk("latency", 128'(n), 128'((lat == 0) ? 3 : lat + 2));
        chk("core_in_held", 128'(held), 128'd1);
        chk("ct", bus.ct, exp_ct);
        chk("in_ready_out", 128'(bus.in_ready), 128'd0);
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            smp();
            if (!bus.out_valid || bus.ct !== exp_ct || bus.in_ready) stable = 1'b0;
        end
        chk("out_hold", 128'(stable), 128'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        smp();
        chk("out_valid_drop", 128'(bus.out_valid), 128'd0);
        chk("in_ready_back", 128'(bus.in_ready), 128'd1);
        chk("core_rst_once", 128'(rst_pulses - p0), 128'd1);
    endtask

    localparam blk_t PT0  = 128'ha3994b66ad85a3459f44e92b08f550cb;
    localparam blk_t KEY0 = 128'hab1afac2611012cd8cef952618c3ebe8;
    localparam blk_t TW0  = 128'hab588a34a47f1ab2dfe9c8293fbea9a5;
    localparam blk_t CNT0 = 128'hdf889548cfc7ea52d296339301797449;
    localparam blk_t PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam blk_t KEY1 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam blk_t TW1  = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam blk_t CNT1 = 128'h00000000000000000000000000000001;
    localparam blk_t MS0  = 128'h5a5a5a5a_11223344_55667788_99aabbcc;
    localparam blk_t MK0  = 128'hc3c3c3c3_87654321_0badf00d_feedface;
    localparam blk_t MR0  = 128'h13579bdf_2468ace0_fedcba98_76543210;

    int  n;
    bit  ov;

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.rnd_valid = 1'b0; bus.out_ready = 1'b0;
        bus.pt = '0; bus.key = '0; bus.tweak = '0; bus.cnt = '0; bus.rnd_i = '0;
        repeat (3) tick();
        smp();
        chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_core_rst", 128'(bus.core_rst), 128'd0);
        chk("rst_err", 128'(bus.err), 128'd0);
        chk("rst_ct", bus.ct, 128'd0);
        chk("rst_shares", bus.sshi0 | bus.sshi1 | bus.kshi0 | bus.kshi1, 128'd0);
        chk("rst_core_side", bus.ri | bus.ti | bus.cnti, 128'd0);
        rst = 1'b0;
        tick();
        smp();
        chk("idle_in_ready", 128'(bus.in_ready), 128'd1);

        // Reference vector, continuous randomness.
        do_req(PT0, KEY0, TW0, CNT0, MS0, MK0, MR0, 0, 4, 0, 1'b0);
        // Randomness valid one cycle in four; stray in_valid during masking; done early.
        do_req(PT0, KEY0, TW0, CNT0, ~MS0, ~MK0, ~MR0, 3, 0, 0, 1'b1);
        // Two back-to-back requests with a 10-cycle output stall each.
        do_req(PT0, KEY0, TW0, CNT0, MK0, MR0, MS0, 0, 1, 10, 1'b0);
        do_req(PT1, KEY1, TW1, CNT1, MR0, MS0, MK0, 1, 2, 10, 1'b0);

        // Reset while the core is running.
        core_hang = 1'b1;
        start_req(PT1, KEY1, TW1, CNT1, MS0, MK0, MR0, 0, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        smp();
        chk("midrun_rst_in_ready", 128'(bus.in_ready), 128'd0);
        chk("midrun_out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrun_shares", bus.sshi0 | bus.sshi1 | bus.kshi0 | bus.kshi1, 128'd0);
        chk("midrun_core_side", bus.ri | bus.ti | bus.cnti | bus.ct, 128'd0);
        rst = 1'b0;
        tick();
        smp();
        chk("midrun_idle", 128'(bus.in_ready), 128'd1);
        do_req(PT1, KEY1, TW1, CNT1, MK0, MS0, MR0, 0, 3, 0, 1'b0);

        // Core never finishes.
        core_hang = 1'b1;
        start_req(PT0, KEY0, TW0, CNT0, MS0, MK0, MR0, 0, 1'b0);
        n = 0;
        ov = 1'b0;
        while (!bus.err && n < 1200) begin
            tick();
            smp();
            n++;
            if (bus.out_valid) ov = 1'b1;
        end
`ifdef DOM1_SKINNY_WDT_EN
        chk("wdt_cycles", 128'(n), 128'd1025);
        chk("wdt_no_out", 128'(ov), 128'd0);
        chk("wdt_idle", 128'(bus.in_ready), 128'd1);
        tick();
        smp();
        chk("wdt_err_pulse", 128'(bus.err), 128'd0);
`else
        chk("no_wdt_cycles", 128'(n), 128'd1200);
        chk("no_wdt_err", 128'(bus.err), 128'd0);
        chk("no_wdt_busy", 128'(bus.in_ready), 128'd0);
        chk("no_wdt_no_out", 128'(ov), 128'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        do_req(PT0, KEY0, TW0, CNT0, MR0, MK0, MS0, 0, 2, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
